gauss_kernel_streamer: RTL and testbench

//  Streams the fixed-point 1-D Gaussian kernel of every enabled scale of a SIFT octave (sigma_s = SIG0*SIGK^s).

---
 rtl/gauss_kernel_streamer_pkg.sv | 95 +++++++++
 rtl/gauss_kernel_streamer_if.sv | 35 +++
 rtl/gauss_kernel_streamer_rom.sv | 49 ++++
 rtl/gauss_kernel_streamer.sv | 217 +++++++++++++++++++++
 tb/tb_gauss_kernel_streamer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gauss_kernel_streamer_pkg.sv
// gauss_kernel_streamer_pkg
//   Shared types and elaboration-time helpers for the Gaussian kernel streamer.
//   Holds the FSM state type, the derived-width functions and the real-valued
//   constant functions that build the coefficient table.
//   No ports (package).
package gauss_kernel_streamer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Scale index width; kept at least 1 bit so a single-scale build still has a port.
  function automatic int calc_sw(input int nscale);
    return (nscale > 1) ? $clog2(nscale) : 1;
  endfunction

  // Unsigned tap index width (0..WIN-1) used to address the table.
  function automatic int calc_xw(input int win);
    return (win > 1) ? $clog2(win) : 1;
  endfunction

  // Signed tap offset width.
  function automatic int calc_tw(input int win);
    return $clog2(win / 2 + 1) + 1;
  endfunction

  function automatic int calc_sumw(input int cw, input int win);
    return cw + $clog2(win);
  endfunction

  // e^-a for a >= 0: argument scaled down by 64, Taylor series, then squared
  // back up six times. Accurate well past what a 9..16 bit table needs.
  function automatic real exp_neg(input real a);
    real y;
    real term;
    real e;
    y    = a / 64.0;
    term = 1.0;
    e    = 1.0;
    for (int n = 1; n <= 20; n++) begin
      term = term * y / real'(n);
      e    = e + term;
    end
    for (int k = 0; k < 6; k++) begin
      e = e * e;
    end
    return 1.0 / e;
  endfunction

  function automatic real sigma_of(input real sig0, input real sigk, input int s);
    real sg;
    sg = sig0;
    for (int i = 0; i < s; i++) begin
      sg = sg * sigk;
    end
    return sg;
  endfunction

  function automatic real gauss_w(input real sigma, input int x);
    return exp_neg(real'(x * x) / (2.0 * sigma * sigma));
  endfunction

  // Normalised, rounded and clamped coefficient of scale s at signed tap x.
  function automatic int coef_val(input int cw, input int win, input real sig0,
                                  input real sigk, input int s, input int x);
    int  radi;
    int  cmax;
    int  c;
    real sigma;
    real tot;
    real v;
    radi  = win / 2;
    sigma = sigma_of(sig0, sigk, s);
    tot   = 0.0;
    for (int k = -radi; k <= radi; k++) begin
      tot = tot + gauss_w(sigma, k);
    end
    cmax = (1 << cw) - 1;
    v    = real'(cmax) * gauss_w(sigma, x) / tot;
    c    = $rtoi(v + 0.5);
    return (c > cmax) ? cmax : c;
  endfunction

  function automatic int coef_sum(input int cw, input int win, input real sig0,
                                  input real sigk, input int s);
    int acc;
    acc = 0;
    for (int x = -(win / 2); x <= win / 2; x++) begin
      acc = acc + coef_val(cw, win, sig0, sigk, s, x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gauss_kernel_streamer_if.sv
// gauss_kernel_streamer_if
//   Coefficient stream between the kernel streamer and a blur engine.
//   master: drives valid, coef, scale, tap, sum, first_beat, last_beat, frame_last; samples ready
//   slave : the reverse
interface gauss_kernel_streamer_if
  import gauss_kernel_streamer_pkg::*;
#(
  parameter int NSCALE = 5,
  parameter int WIN    = 19,
  parameter int CW     = 9
);
  localparam int SW   = calc_sw(NSCALE);
  localparam int TW   = calc_tw(WIN);
  localparam int SUMW = calc_sumw(CW, WIN);

  logic                   valid;
  logic                   ready;
  logic [CW-1:0]          coef;
  logic [SW-1:0]          scale;
  logic signed [TW-1:0]   tap;
  logic [SUMW-1:0]        sum;
  logic                   first_beat;
  logic                   last_beat;
  logic                   frame_last;

  modport master (
    output valid, coef, scale, tap, sum, first_beat, last_beat, frame_last,
    input  ready
  );

  modport slave (
    input  valid, coef, scale, tap, sum, first_beat, last_beat, frame_last,
    output ready
  );
endinterface

// File: rtl/gauss_kernel_streamer_rom.sv
// gauss_kernel_streamer_rom
//   Constant coefficient table [scale][tap index] plus per-scale kernel sum,
//   both built at elaboration, read through one registered port.
//   clk, rst_n        : clock / async active-low reset (read register clears)
//   rd_en             : load the read register
//   rd_scale, rd_idx  : scale and unsigned tap index (tap + RADI)
//   coef, sum         : registered table outputs
module gauss_kernel_streamer_rom
  import gauss_kernel_streamer_pkg::*;
#(
  parameter int  NSCALE = 5,
  parameter int  WIN    = 19,
  parameter int  CW     = 9,
  parameter real SIG0   = 1.6,
  parameter real SIGK   = 1.414
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_en,
  input  logic [calc_sw(NSCALE)-1:0]     rd_scale,
  input  logic [calc_xw(WIN)-1:0]        rd_idx,
  output logic [CW-1:0]                  coef,
  output logic [calc_sumw(CW, WIN)-1:0]  sum
);
  localparam int RADI = WIN / 2;
  localparam int SUMW = calc_sumw(CW, WIN);

  logic [CW-1:0]   coef_tab [NSCALE][WIN];
  logic [SUMW-1:0] sum_tab  [NSCALE];

  for (genvar s = 0; s < NSCALE; s++) begin : g_scale
    localparam int SUM_V = coef_sum(CW, WIN, SIG0, SIGK, s);
    assign sum_tab[s] = SUMW'(SUM_V);
    for (genvar x = 0; x < WIN; x++) begin : g_tap
      localparam int COEF_V = coef_val(CW, WIN, SIG0, SIGK, s, x - RADI);
      assign coef_tab[s][x] = CW'(COEF_V);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef <= '0;
      sum  <= '0;
    end else if (rd_en) begin
      coef <= coef_tab[rd_scale][rd_idx];
      sum  <= sum_tab[rd_scale];
    end
  end
endmodule

// File: rtl/gauss_kernel_streamer.sv
// gauss_kernel_streamer
//   Streams the Gaussian kernel of every enabled scale, one coefficient per
//   valid/ready beat, optionally only the non-negative half, optionally looping.
//   clk, rst_n   : clock / async active-low reset
//   start        : begin a frame (ignored while busy)
//   abort        : synchronous stop, beats the other controls
//   half_mode    : 1 = taps 0..+RADI, 0 = taps -RADI..+RADI (latched at start)
//   loop_en      : restart immediately after the last beat (sampled on that beat)
//   scale_mask   : enabled scales (latched at start)
//   strm         : coefficient stream (master)
//   busy, done   : FSM not idle / one-cycle end-of-frame pulse
//
//   state   | meaning
//   IDLE    | no beat pending, waiting for start
//   RUN     | a beat is presented on strm, advancing on valid&&ready
module gauss_kernel_streamer
  import gauss_kernel_streamer_pkg::*;
#(
  parameter int  NSCALE = 5,
  parameter int  WIN    = 19,
  parameter int  CW     = 9,
  parameter real SIG0   = 1.6,
  parameter real SIGK   = 1.414
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    half_mode,
  input  logic                    loop_en,
  input  logic [NSCALE-1:0]       scale_mask,
  gauss_kernel_streamer_if.master strm,
  output logic                    busy,
  output logic                    done
);
  localparam int RADI = WIN / 2;
  localparam int SW   = calc_sw(NSCALE);
  localparam int XW   = calc_xw(WIN);
  localparam int TW   = calc_tw(WIN);
  localparam int SUMW = calc_sumw(CW, WIN);

  state_t               state_q, state_d;
  logic [NSCALE-1:0]    mask_q, mask_d;
  logic                 half_q, half_d;
  logic [XW-1:0]        idx_q, idx_d;
  logic [SW-1:0]        scale_q, scale_d;
  logic signed [TW-1:0] tap_q;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 first_q, last_q, flast_q;
  logic                 first_d, last_d, flast_d;
  logic                 load;
  logic [CW-1:0]        rom_coef;
  logic [SUMW-1:0]      rom_sum;

  function automatic logic [SW-1:0] lowest_set(input logic [NSCALE-1:0] m);
    logic [SW-1:0] r;
    r = '0;
    for (int i = NSCALE - 1; i >= 0; i--) begin
      if (m[i]) r = SW'(i);
    end
    return r;
  endfunction

  // Lowest enabled scale strictly above s; disabled scales are skipped in zero cycles.
  function automatic logic [SW-1:0] next_set(input logic [NSCALE-1:0] m, input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = '0;
    for (int i = NSCALE - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) r = SW'(i);
    end
    return r;
  endfunction

  function automatic logic any_above(input logic [NSCALE-1:0] m, input logic [SW-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NSCALE; i++) begin
      if (m[i] && (i > int'(s))) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [XW-1:0] start_idx(input logic h);
    return h ? XW'(RADI) : '0;
  endfunction

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    half_d  = half_q;
    idx_d   = idx_q;
    scale_d = scale_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = scale_mask;
          half_d = half_mode;
          if (scale_mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            load    = 1'b1;
            scale_d = lowest_set(scale_mask);
            idx_d   = start_idx(half_mode);
          end
        end
      end
      ST_RUN: begin
        if (valid_q && strm.ready) begin
          if (!last_q) begin
            load  = 1'b1;
            idx_d = idx_q + XW'(1);
          end else if (!flast_q) begin
            load    = 1'b1;
            scale_d = next_set(mask_q, scale_q);
            idx_d   = start_idx(half_q);
          end else begin
            done_d = 1'b1;
            if (loop_en) begin
              load    = 1'b1;
              scale_d = lowest_set(mask_q);
              idx_d   = start_idx(half_q);
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
      load    = 1'b0;
      mask_d  = mask_q;
      half_d  = half_q;
      idx_d   = idx_q;
      scale_d = scale_q;
    end
  end

  // Flags are computed for the beat being loaded so they land with its coefficient.
  always_comb begin
    first_d = (idx_d == start_idx(half_d));
    last_d  = (idx_d == XW'(WIN - 1));
    flast_d = last_d && !any_above(mask_d, scale_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      half_q  <= 1'b0;
      idx_q   <= '0;
      scale_q <= '0;
      tap_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      flast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      half_q  <= half_d;
      if (load) begin
        idx_q   <= idx_d;
        scale_q <= scale_d;
        tap_q   <= TW'(int'(idx_d) - RADI);
        first_q <= first_d;
        last_q  <= last_d;
        flast_q <= flast_d;
      end
    end
  end

  gauss_kernel_streamer_rom #(
    .NSCALE (NSCALE),
    .WIN    (WIN),
    .CW     (CW),
    .SIG0   (SIG0),
    .SIGK   (SIGK)
  ) u_rom (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (load),
    .rd_scale (scale_d),
    .rd_idx   (idx_d),
    .coef     (rom_coef),
    .sum      (rom_sum)
  );

  assign strm.valid      = valid_q;
  assign strm.coef       = rom_coef;
  assign strm.sum        = rom_sum;
  assign strm.scale      = scale_q;
  assign strm.tap        = tap_q;
  assign strm.first_beat = first_q;
  assign strm.last_beat  = last_q;
  assign strm.frame_last = flast_q;
  assign busy            = (state_q == ST_RUN);
  assign done            = done_q;
endmodule

// File: tb/tb_gauss_kernel_streamer.sv
// tb_gauss_kernel_streamer
//   Scoreboard bench: stimulus pushes the expected beat sequence computed from
//   the Gaussian formula; a negedge monitor pops and compares accepted beats,
//   checks hold-while-stalled and the done pulse timing.
module tb_gauss_kernel_streamer;
  localparam int NS = 5;
  localparam int W  = 19;
  localparam int R  = W / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          half_mode = 1'b0;
  logic          loop_en = 1'b0;
  logic [NS-1:0] scale_mask = '0;
  logic          busy;
  logic          done;

  gauss_kernel_streamer_if #(.NSCALE(NS), .WIN(W), .CW(9)) strm ();

  gauss_kernel_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .half_mode  (half_mode),
    .loop_en    (loop_en),
    .scale_mask (scale_mask),
    .strm       (strm),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int coef;
    int scale;
    int tap;
    int sum;
    bit first;
    bit last;
    bit fl;
  } beat_t;

  beat_t exp_q[$];
  int    mcoef[NS][W];
  int    msum[NS];
  int    checks = 0;
  int    fails = 0;
  int    accepted = 0;
  bit    rand_rdy = 0;
  bit    rdy_level = 1;
  bit    zero_start = 0;

  logic [33:0] cur_vec;
  assign cur_vec = {strm.coef, strm.scale, strm.tap, strm.sum,
                    strm.first_beat, strm.last_beat, strm.frame_last};

  // Reference kernel straight from the Gaussian definition.
  task automatic build_model();
    real sigma, tot, v;
    int  c;
    for (int s = 0; s < NS; s++) begin
      sigma = 1.6;
      for (int i = 0; i < s; i++) sigma = sigma * 1.414;
      tot = 0.0;
      for (int k = -R; k <= R; k++) tot = tot + $exp(-real'(k * k) / (2.0 * sigma * sigma));
      msum[s] = 0;
      for (int x = -R; x <= R; x++) begin
        v = 511.0 * $exp(-real'(x * x) / (2.0 * sigma * sigma)) / tot;
        c = int'($floor(v + 0.5));
        if (c > 511) c = 511;
        mcoef[s][x + R] = c;
        msum[s] += c;
      end
    end
  endtask

  task automatic push_frame(input logic [NS-1:0] m, input bit h);
    beat_t b;
    int    top;
    top = -1;
    for (int s = 0; s < NS; s++) if (m[s]) top = s;
    for (int s = 0; s < NS; s++) begin
      if (m[s]) begin
        for (int x = (h ? 0 : -R); x <= R; x++) begin
          b.coef  = mcoef[s][x + R];
          b.scale = s;
          b.tap   = x;
          b.sum   = msum[s];
          b.first = (x == (h ? 0 : -R));
          b.last  = (x == R);
          b.fl    = (x == R) && (s == top);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({strm.valid, cur_vec, busy, done} !== '0) begin
      fails++;
      $display("FAIL %s_outputs: got %h want 0", tag, {strm.valid, cur_vec, busy, done});
    end
  endtask

  task automatic start_frame(input logic [NS-1:0] m, input bit h);
    push_frame(m, h);
    @(posedge clk); #1;
    scale_mask = m;
    half_mode  = h;
    start      = 1'b1;
    zero_start = (m == '0);
    @(posedge clk); #1;
    start      = 1'b0;
    zero_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < budget);
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    strm.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      strm.ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Monitor / scoreboard
  beat_t       e;
  logic        exp_done = 1'b0;
  logic        nxt_done;
  logic        stalled = 1'b0;
  logic [33:0] snap;
  int          acc = 0;
  bit          acc_full = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done = 1'b0;
      stalled  = 1'b0;
    end else begin
      checks++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL done_pulse t=%0t: got %b want %b", $time, done, exp_done);
      end
      nxt_done = zero_start && !abort;
      if (stalled) begin
        checks++;
        if (strm.valid !== 1'b1 || cur_vec !== snap) begin
          fails++;
          $display("FAIL stall_hold t=%0t: got %b/%h want 1/%h", $time, strm.valid, cur_vec, snap);
        end
      end
      stalled = strm.valid && !strm.ready && !abort;
      snap    = cur_vec;
      if (strm.valid === 1'b1 && strm.ready && !abort) begin
        accepted++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat t=%0t: scale %0d tap %0d", $time, strm.scale, strm.tap);
        end else begin
          e = exp_q.pop_front();
          if (strm.coef !== 9'(e.coef) || strm.scale !== 3'(e.scale) || strm.tap !== 5'(e.tap)) begin
            fails++;
            $display("FAIL beat t=%0t: got coef %0d s %0d tap %0d want coef %0d s %0d tap %0d",
                     $time, strm.coef, strm.scale, strm.tap, e.coef, e.scale, e.tap);
          end
          checks++;
          if (strm.sum !== 14'(e.sum)) begin
            fails++;
            $display("FAIL out_sum: got %0d want %0d", strm.sum, e.sum);
          end
          checks++;
          if ({strm.first_beat, strm.last_beat, strm.frame_last} !== {e.first, e.last, e.fl}) begin
            fails++;
            $display("FAIL flags s%0d tap %0d: got %b want %b", e.scale, e.tap,
                     {strm.first_beat, strm.last_beat, strm.frame_last}, {e.first, e.last, e.fl});
          end
          if (e.scale == 0 && e.tap == 0) begin
            checks++;
            if (strm.coef !== 9'd127) begin
              fails++;
              $display("FAIL center_coef: got %0d want 127", strm.coef);
            end
          end
          if (e.scale == 0 && (e.tap == R || e.tap == -R)) begin
            checks++;
            if (strm.coef !== 9'd0) begin
              fails++;
              $display("FAIL edge_coef tap %0d: got %0d want 0", e.tap, strm.coef);
            end
          end
          if (e.first) begin
            acc      = 0;
            acc_full = (e.tap == -R);
          end
          acc += int'(strm.coef);
          if (e.last && acc_full) begin
            checks++;
            if (acc != int'(strm.sum)) begin
              fails++;
              $display("FAIL beat_sum s%0d: got %0d want %0d", e.scale, acc, strm.sum);
            end
          end
          nxt_done = nxt_done || e.fl;
        end
      end
      exp_done = nxt_done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    build_model();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;

    // 1: all scales, full kernel, ready always high
    base = accepted;
    start_frame(5'b11111, 1'b0);
    wait_done(300, c);
    expect_int("t1_cycles_to_done", c, 96);
    expect_int("t1_beats", accepted - base, 95);
    @(negedge clk);
    expect_int("t1_idle_busy", int'(busy), 0);

    // 2: scales 2 and 4, half kernel
    base = accepted;
    start_frame(5'b10100, 1'b1);
    wait_done(100, c);
    expect_int("t2_cycles_to_done", c, 21);
    expect_int("t2_beats", accepted - base, 20);

    // 3: random backpressure
    rand_rdy = 1;
    base = accepted;
    start_frame(5'b11111, 1'b0);
    wait_done(3000, c);
    expect_int("t3_beats", accepted - base, 95);
    rand_rdy = 0;

    // 4: empty mask
    base = accepted;
    start_frame(5'b00000, 1'b0);
    expect_int("t4_busy_after_start", int'(busy), 0);
    wait_done(10, c);
    expect_int("t4_cycles_to_done", c, 1);
    expect_int("t4_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    expect_int("t4_valid", int'(strm.valid), 0);
    expect_int("t4_beats", accepted - base, 0);

    // 5: two looped frames, no bubble
    loop_en = 1'b1;
    base = accepted;
    push_frame(5'b11111, 1'b0);
    start_frame(5'b11111, 1'b0);
    wait_done(300, c);
    expect_int("t5_first_done", c, 96);
    @(posedge clk); #1 loop_en = 1'b0;
    wait_done(300, c);
    expect_int("t5_second_done", c, 95);
    expect_int("t5_beats", accepted - base, 190);
    repeat (2) @(negedge clk);
    expect_int("t5_idle", int'(busy), 0);

    // 6a: abort while beat 40 is presented
    base = accepted;
    start_frame(5'b11111, 1'b0);
    repeat (39) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    expect_int("t6_valid_after_abort", int'(strm.valid), 0);
    expect_int("t6_busy_after_abort", int'(busy), 0);
    expect_int("t6_beats_before_abort", accepted - base, 39);
    exp_q.delete();
    repeat (5) @(negedge clk);

    // 6b: start while running is ignored
    base = accepted;
    start_frame(5'b10100, 1'b1);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; scale_mask = 5'b00001; half_mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, c);
    expect_int("t6_run_start_beats", accepted - base, 20);

    // 6c: async reset mid-frame
    start_frame(5'b11111, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("midframe_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    expect_int("post_reset_busy", int'(busy), 0);

    expect_int("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
